// File: rtl/alu_isa_pkg.sv
// ISA constants, field positions and shared types for the ALU issue unit.
// Illegal-opcode trapping is selected by ALU_ISSUE_ILLEGAL_TRAP_EN.
package alu_isa_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned SHAMT_W = 5;

    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned RD_MSB  = 25;
    localparam int unsigned RD_LSB  = 21;
    localparam int unsigned RS1_MSB = 20;
    localparam int unsigned RS1_LSB = 16;
    localparam int unsigned RS2_MSB = 15;
    localparam int unsigned RS2_LSB = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_R_BASE = 6'h00;
    localparam logic [OP_W-1:0] OP_I_BASE = 6'h08;
    localparam logic [OP_W-1:0] OP_BEQ    = 6'h10;
    localparam logic [OP_W-1:0] OP_BNE    = 6'h11;
    localparam logic [OP_W-1:0] OP_NOP    = 6'h3F;

    localparam logic [SEL_W-1:0] ALU_ADD = 3'd0;
    localparam logic [SEL_W-1:0] ALU_SUB = 3'd1;
    localparam logic [SEL_W-1:0] ALU_NOT = 3'd2;
    localparam logic [SEL_W-1:0] ALU_LSL = 3'd3;
    localparam logic [SEL_W-1:0] ALU_LSR = 3'd4;
    localparam logic [SEL_W-1:0] ALU_AND = 3'd5;
    localparam logic [SEL_W-1:0] ALU_OR  = 3'd6;
    localparam logic [SEL_W-1:0] ALU_SLT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2
    } br_type_t;

    typedef struct packed {
        logic [SEL_W-1:0] alu_sel;
        logic             imm_en;
        logic             shift_mask;
        logic             wb_en;
        br_type_t         br_type;
        logic             illegal;
    } dec_ctrl_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder producing the ALU control bundle.
// ALU_ISSUE_ILLEGAL_TRAP_EN: flag undefined opcodes; otherwise they decode as NOP.
module alu_op_decode
    import alu_isa_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output dec_ctrl_t       ctrl
);

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    always_comb begin
        ctrl.alu_sel    = ALU_ADD;
        ctrl.imm_en     = 1'b0;
        ctrl.shift_mask = 1'b0;
        ctrl.wb_en      = 1'b0;
        ctrl.br_type    = BR_NONE;
        ctrl.illegal    = 1'b0;

        // 0x00-0x0F: R-type when op[3]=0, I-type when op[3]=1
        if (op[OP_W-1:OP_W-2] == 2'b00) begin
            ctrl.alu_sel    = op[SEL_W-1:0];
            ctrl.imm_en     = op[3];
            ctrl.wb_en      = 1'b1;
            ctrl.shift_mask = (op[SEL_W-1:0] == ALU_LSL) || (op[SEL_W-1:0] == ALU_LSR);
        end else if ((op == OP_BEQ) || (op == OP_BNE)) begin
            ctrl.alu_sel = ALU_SUB;
            ctrl.br_type = (op == OP_BEQ) ? BR_EQ : BR_NE;
        end else if (op != OP_NOP) begin
            ctrl.illegal = TRAP_EN;
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue stage for an external combinational ALU: decode, operand launch, result capture.
// Illegal-opcode trapping follows ALU_ISSUE_ILLEGAL_TRAP_EN (applied in alu_op_decode).
module alu_issue_unit
    import alu_isa_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [DATA_W-1:0]   in_pc,
    input  logic [DATA_W-1:0]   in_rs1_data,
    input  logic [DATA_W-1:0]   in_rs2_data,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [SEL_W-1:0]    alu_sel,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_zero,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [REG_W-1:0]    out_rd,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_wb_en,
    output logic                out_br_taken,
    output logic [DATA_W-1:0]   out_br_target,
    output logic                out_illegal
);

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    logic                 capture;
    dec_ctrl_t            dec;
    logic [DATA_W-1:0]    imm_sext;
    logic [DATA_W-1:0]    b_sel;
    logic [DATA_W-1:0]    b_op;
    logic [DATA_W-1:0]    br_target_c;

    logic [REG_W-1:0]     pend_rd;
    logic                 pend_wb_en;
    br_type_t             pend_br_type;
    logic [DATA_W-1:0]    pend_br_target;
    logic                 pend_illegal;

    // Register indices arrive pre-read; the rs1 index field is not needed here.
    logic                 unused_rs1_idx;
    assign unused_rs1_idx = ^in_instr[RS1_MSB:RS1_LSB];

    alu_op_decode u_decode (
        .op   (in_instr[OP_MSB:OP_LSB]),
        .ctrl (dec)
    );

    assign imm_sext    = {{(DATA_W-IMM_W){in_instr[IMM_MSB]}}, in_instr[IMM_MSB:IMM_LSB]};
    assign b_sel       = dec.imm_en ? imm_sext : in_rs2_data;
    assign b_op        = dec.shift_mask ? {{(DATA_W-SHAMT_W){1'b0}}, b_sel[SHAMT_W-1:0]} : b_sel;
    assign br_target_c = in_pc + (imm_sext << BR_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = in_valid ? ST_EXEC : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        capture  = 1'b0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_EXEC: capture  = 1'b1;
            ST_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid & in_ready;

    // Operand launch on accept; result capture at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a          <= '0;
            alu_b          <= '0;
            alu_sel        <= '0;
            pend_rd        <= '0;
            pend_wb_en     <= 1'b0;
            pend_br_type   <= BR_NONE;
            pend_br_target <= '0;
            pend_illegal   <= 1'b0;
            out_valid      <= 1'b0;
            out_rd         <= '0;
            out_data       <= '0;
            out_wb_en      <= 1'b0;
            out_br_taken   <= 1'b0;
            out_br_target  <= '0;
            out_illegal    <= 1'b0;
        end else begin
            if (accept) begin
                alu_a          <= in_rs1_data;
                alu_b          <= b_op;
                alu_sel        <= dec.alu_sel;
                pend_rd        <= in_instr[RD_MSB:RD_LSB];
                pend_wb_en     <= dec.wb_en;
                pend_br_type   <= dec.br_type;
                pend_br_target <= br_target_c;
                pend_illegal   <= dec.illegal;
            end
            if (capture) begin
                out_valid     <= 1'b1;
                out_rd        <= pend_rd;
                out_data      <= alu_result;
                out_wb_en     <= pend_wb_en;
                out_br_taken  <= ((pend_br_type == BR_EQ) &&  alu_zero) ||
                                 ((pend_br_type == BR_NE) && !alu_zero);
                out_br_target <= pend_br_target;
                out_illegal   <= pend_illegal;
            end else if ((state == ST_DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
